// File: rtl/shiftreg_digit.sv
// Digit-serial shift register: parallel load of a WIDTH-bit operand, emitted
// DIGIT bits per shift, LSB- or MSB-first, with remaining-digit tracking.
module shiftreg_digit #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             clear,
  input  logic             load,
  input  logic             shift,
  input  logic             msb_first,
  input  logic [WIDTH-1:0] A,
  input  logic [DIGIT-1:0] din,
  output logic [DIGIT-1:0] dout,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             last,
  output logic             done
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);

  generate
    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("shiftreg_digit: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_lsb_next;
  logic [WIDTH-1:0] sr_msb_next;
  logic [CW-1:0]    cnt_q;
  logic             dir_q;
  logic             done_q;

  // A single-digit operand has no bits left to keep, so a shift is a plain replace.
  generate
    if (DIGIT == WIDTH) begin : g_full
      assign sr_lsb_next = din;
      assign sr_msb_next = din;
    end else begin : g_part
      assign sr_lsb_next = {din, sr_q[WIDTH-1:DIGIT]};
      assign sr_msb_next = {sr_q[WIDTH-DIGIT-1:0], din};
    end
  endgenerate

  assign busy = (cnt_q != '0);
  assign last = busy && (cnt_q == CW'(1));
  assign q    = sr_q;
  assign dout = dir_q ? sr_q[WIDTH-1 -: DIGIT] : sr_q[DIGIT-1:0];
  assign done = done_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      dir_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      // NOTE: done defaults low every edge, outside the ena gate, so the pulse
      // self-clears even while the rest of the state is frozen.
      done_q <= 1'b0;
      if (ena) begin
        if (!clear) begin
          sr_q  <= '0;
          cnt_q <= '0;
          dir_q <= 1'b0;
        end else if (load) begin
          sr_q  <= A;
          cnt_q <= CW'(NDIG);
          dir_q <= msb_first;
        end else if (shift && busy) begin
          sr_q  <= dir_q ? sr_msb_next : sr_lsb_next;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) done_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/shiftreg_digit.md
# shiftreg_digit

Parametrised digit-serial shift register for the RSA datapath. It takes a WIDTH-bit operand on a parallel load and presents it DIGIT bits at a time, least-significant or most-significant digit first. It refills vacated positions from a serial digit input and tracks the remaining digits with an internal counter, raising `last` and `done` flags. It feeds the digit-serial modular multiplier; with DIGIT=1 and `msb_first`=0 it gives plain bit-serial LSB-first behaviour.

## Interface
- WIDTH, default 32: operand width in bits; must be a multiple of DIGIT (elaboration error otherwise).
- DIGIT, default 1: digit width in bits emitted per shift; 1 ≤ DIGIT ≤ WIDTH.
- NDIG (local): WIDTH/DIGIT, digits per operand. Counter width CW = $clog2(NDIG+1).

Clock and reset: one clock; reset is asynchronous and active-low (`clk`, `rstb`).

- clk  in  1  clock; all state updates on rising edge.
- rstb  in  1  asynchronous active-low reset.
- ena  in  1  clock enable; when low no state changes, except that `done` still self-clears.
- clear  in  1  synchronous clear, active-low; takes effect only with ena=1.
- load  in  1  parallel load of A; starts a new operand.
- shift  in  1  advance one digit.
- msb_first  in  1  direction; sampled on load only.
- A  in  WIDTH  parallel operand.
- din  in  DIGIT  fill digit shifted into the vacated end.
- dout  out  DIGIT  current digit: reg[DIGIT-1:0] (LSB-first) or reg[WIDTH-1:WIDTH-DIGIT] (MSB-first).
- q  out  WIDTH  full register contents.
- busy  out  1  digits remain (cnt != 0).
- last  out  1  busy and cnt == 1.
- done  out  1  one-cycle pulse after the final digit is shifted out.

## Operation
- State:
  - reg[WIDTH-1:0]
  - cnt[CW-1:0]
  - dir (latched msb_first)
  - done register
- Priority when ena=1: clear==0 > load==1 > (shift==1 and busy) > hold.
- Clear: reg←0, cnt←0, dir←0, done←0. Any operation in progress is aborted without a done pulse.
- Load: reg←A, cnt←NDIG, dir←msb_first, done←0. Load while busy restarts without a done pulse.
- Shift, dir=0: reg←{din, reg[WIDTH-1:DIGIT]}.
- Shift, dir=1: reg←{reg[WIDTH-DIGIT-1:0], din}.
- Shift, both directions: cnt←cnt-1. If cnt was 1, done←1 at that edge.
- Shift with busy=0: ignored; reg, cnt and done are unchanged.
- Hold: reg, cnt and dir are unchanged.
- done is high for exactly one clk cycle. It is cleared on the following rising edge regardless of ena.
- Special case DIGIT==WIDTH: NDIG=1, and a single shift replaces reg with din.
- dout, q, busy and last are combinational from state; none depend combinationally on inputs.

## Timing
- Reset values: reg=0, cnt=0, dir=0, so dout=0, q=0, busy=0, last=0, done=0.
- Reset asserted mid-operation: immediate, asynchronous return to reset values. No done pulse.
- Load at edge N: the first digit is on dout and busy=1 immediately after edge N.
- Each accepted shift edge presents the next digit after that edge, with zero added latency.
- With back-to-back shifts, the NDIG digits occupy NDIG consecutive cycles.
- The final digit is on dout while last=1.
- The edge consuming the final digit drops busy and last and raises done for one cycle.
- A load on the same edge as done rising is legal: load wins and done is suppressed.
- ena=0 for any number of cycles freezes reg, cnt and dir exactly. Operation resumes with no lost or duplicated digit.
- Simultaneous load and shift: load only; no digit is consumed.

## Test plan
- Reset: assert rstb=0 asynchronously mid-stream → all outputs 0 immediately; no done pulse afterwards.
- LSB-first, WIDTH=8, DIGIT=2, A=0xB4, load then 4 shifts with din=1:
  - dout sequence 0,1,3,2.
  - last high only during digit 2.
  - done pulses on the cycle after the 4th shift edge.
  - final q=0x55, busy=0.
- MSB-first, same A and din=1:
  - dout sequence 2,3,1,0.
  - final q=0x55, single done pulse.
  - a 5th shift is ignored (q stays 0x55, no second done).
- ena gating, WIDTH=4, DIGIT=1, A=0xA, LSB-first:
  - insert 3 ena=0 cycles between shifts → dout 0,1,0,1 with no skips or repeats.
  - clear=0 with ena=0 has no effect.
- Priority, mid-operation WIDTH=8, DIGIT=2:
  - clear=0 with load=1 → all zero, no done.
  - then load=1 with shift=1 and A=0x3C → dout=0, cnt restarts at 4.
  - load on the final shift edge → no done, new operand active.
